// File: rtl/branch_unit_if.sv
// Decoder/register-file side bundle of the branch unit.
// slave is the branch unit; master is whoever drives its requests and read data.
interface branch_unit_if #(
    parameter int DATA_W   = 32,
    parameter int OFFSET_W = 24
);
    logic                en;
    logic                cond;
    logic [1:0]          mode;
    logic [OFFSET_W-1:0] offset;
    logic [3:0]          rm;
    logic                busy;
    logic                done;
    logic                write_en;
    logic [3:0]          write_reg;
    logic [DATA_W-1:0]   write_value;
    logic                read_en;
    logic [3:0]          read_reg;
    logic [DATA_W-1:0]   read_value;
    logic                t_write_en;
    logic                t_value;

    modport master (
        output en, cond, mode, offset, rm, read_value,
        input  busy, done, write_en, write_reg, write_value,
               read_en, read_reg, t_write_en, t_value
    );

    modport slave (
        input  en, cond, mode, offset, rm, read_value,
        output busy, done, write_en, write_reg, write_value,
               read_en, read_reg, t_write_en, t_value
    );
endinterface

// File: rtl/branch_unit.sv
// B / BL / BX / BLX(reg) sequencer over one register-file read port and one write port.
// All outputs are registered; next-cycle output values are built in one combinational block.
module branch_unit #(
    parameter int DATA_W       = 32,
    parameter int OFFSET_W     = 24,
    parameter int OFFSET_SHIFT = 2,
    parameter int PC_AHEAD     = 8,
    parameter int INSTR_BYTES  = 4,
    parameter int RF_RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    branch_unit_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_PC   = 3'd1;
    localparam logic [2:0] S_WAIT_PC = 3'd2;
    localparam logic [2:0] S_RD_RM   = 3'd3;
    localparam logic [2:0] S_WAIT_RM = 3'd4;
    localparam logic [2:0] S_WR_LR   = 3'd5;
    localparam logic [2:0] S_WR_PC   = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam logic [DATA_W-1:0] INC    = DATA_W'(INSTR_BYTES);
    localparam logic [DATA_W-1:0] AHEAD  = DATA_W'(PC_AHEAD);
    localparam logic [2:0]        LAT    = 3'(RF_RD_LAT);
    localparam logic [2:0]        LAT_M1 = 3'(RF_RD_LAT - 1);

    logic [2:0]          state, state_d, cnt, cnt_d;
    logic                cond_q;
    logic [1:0]          mode_q;
    logic [OFFSET_W-1:0] off_q;
    logic [3:0]          rm_q;
    logic [DATA_W-1:0]   pc_q, pc_d, rmv_q, rmv_d;
    logic [DATA_W-1:0]   pc_cur, rmv_cur, tgt, off_ext;
    logic                go_wr, go_pc, take_rm, take_lr;

    logic                busy_q, done_q, rd_en_q, wr_en_q, t_we_q, t_val_q;
    logic [3:0]          rd_reg_q, wr_reg_q;
    logic [DATA_W-1:0]   wr_val_q;
    logic                busy_d, done_d, rd_en_d, wr_en_d, t_we_d, t_val_d;
    logic [3:0]          rd_reg_d, wr_reg_d;
    logic [DATA_W-1:0]   wr_val_d;

    assign take_rm = cond_q & mode_q[1];
    assign take_lr = cond_q & mode_q[0];
    assign off_ext = {{(DATA_W-OFFSET_W){off_q[OFFSET_W-1]}}, off_q} << OFFSET_SHIFT;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        pc_d     = pc_q;
        rmv_d    = rmv_q;
        pc_cur   = pc_q;
        rmv_cur  = rmv_q;
        go_wr    = 1'b0;
        go_pc    = 1'b0;
        tgt      = '0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rd_en_d  = 1'b0;
        rd_reg_d = '0;
        wr_en_d  = 1'b0;
        wr_reg_d = '0;
        wr_val_d = '0;
        t_we_d   = 1'b0;
        t_val_d  = 1'b0;

        case (state)
            S_IDLE: if (bus.en) begin
                state_d  = S_RD_PC;
                busy_d   = 1'b1;
                rd_en_d  = 1'b1;
                rd_reg_d = 4'd15;
            end
            S_RD_PC: begin
                state_d = S_WAIT_PC;
                cnt_d   = '0;
            end
            S_WAIT_PC: if (cnt == LAT_M1) begin
                pc_cur = bus.read_value;
                pc_d   = bus.read_value;
                if (take_rm && rm_q != 4'd15) begin
                    state_d  = S_RD_RM;
                    rd_en_d  = 1'b1;
                    rd_reg_d = rm_q;
                end else begin
                    // Rm == PC never touches the port: the biased PC is the operand
                    rmv_cur = bus.read_value + AHEAD;
                    rmv_d   = rmv_cur;
                    go_wr   = 1'b1;
                end
            end else begin
                cnt_d = cnt + 3'd1;
            end
            S_RD_RM: begin
                state_d = S_WAIT_RM;
                cnt_d   = '0;
            end
            S_WAIT_RM: begin
                // Rm is captured after LAT cycles; one more cycle registers it before the writes
                cnt_d = cnt + 3'd1;
                if (cnt == LAT_M1) rmv_d = bus.read_value;
                if (cnt == LAT)    go_wr = 1'b1;
            end
            S_WR_LR: go_pc = 1'b1;
            S_WR_PC: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (cond_q && !mode_q[1]) tgt = pc_cur + AHEAD + off_ext;
        else if (take_rm)         tgt = {rmv_cur[DATA_W-1:1], 1'b0};
        else                      tgt = pc_cur + INC;

        if (go_wr && take_lr) begin
            state_d  = S_WR_LR;
            wr_en_d  = 1'b1;
            wr_reg_d = 4'd14;
            wr_val_d = pc_cur + INC;
        end else if (go_wr || go_pc) begin
            state_d  = S_WR_PC;
            wr_en_d  = 1'b1;
            wr_reg_d = 4'd15;
            wr_val_d = tgt;
            t_we_d   = take_rm;
            t_val_d  = take_rm & rmv_cur[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cond_q   <= 1'b0;
            mode_q   <= '0;
            off_q    <= '0;
            rm_q     <= '0;
            pc_q     <= '0;
            rmv_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_reg_q <= '0;
            wr_en_q  <= 1'b0;
            wr_reg_q <= '0;
            wr_val_q <= '0;
            t_we_q   <= 1'b0;
            t_val_q  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            pc_q     <= pc_d;
            rmv_q    <= rmv_d;
            if (state == S_IDLE && bus.en) begin
                cond_q <= bus.cond;
                mode_q <= bus.mode;
                off_q  <= bus.offset;
                rm_q   <= bus.rm;
            end
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            rd_reg_q <= rd_reg_d;
            wr_en_q  <= wr_en_d;
            wr_reg_q <= wr_reg_d;
            wr_val_q <= wr_val_d;
            t_we_q   <= t_we_d;
            t_val_q  <= t_val_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.read_en     = rd_en_q;
    assign bus.read_reg    = rd_reg_q;
    assign bus.write_en    = wr_en_q;
    assign bus.write_reg   = wr_reg_q;
    assign bus.write_value = wr_val_q;
    assign bus.t_write_en  = t_we_q;
    assign bus.t_value     = t_val_q;
endmodule

// File: tb/tb_branch_unit.sv
// Directed bench: drives a read-latency-1 and a read-latency-3 branch unit in lockstep,
// each against its own register-file model, and compares against hand-computed results.
module tb_branch_unit;
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    branch_unit_if #(.DATA_W(32), .OFFSET_W(24)) bi1 ();
    branch_unit_if #(.DATA_W(32), .OFFSET_W(24)) bi3 ();

    branch_unit #(.RF_RD_LAT(1)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(bi1));
    branch_unit #(.RF_RD_LAT(3)) u_l3 (.clk(clk), .rst_n(rst_n), .bus(bi3));

    logic        en1, en3, cond;
    logic [1:0]  mode;
    logic [23:0] offset;
    logic [3:0]  rm;

    assign bi1.en = en1;  assign bi1.cond = cond;  assign bi1.mode = mode;
    assign bi1.offset = offset;  assign bi1.rm = rm;
    assign bi3.en = en3;  assign bi3.cond = cond;  assign bi3.mode = mode;
    assign bi3.offset = offset;  assign bi3.rm = rm;

    // register files; read data is valid for exactly one cycle, L edges after read_en is sampled
    logic [31:0] rf1 [16];
    logic [31:0] rf3 [16];
    logic [31:0] p1, p3a, p3b, p3c;
    logic        poke_en;
    logic [3:0]  poke_reg;
    logic [31:0] poke_val;

    always @(posedge clk) begin
        if (poke_en) begin
            rf1[poke_reg] <= poke_val;
            rf3[poke_reg] <= poke_val;
        end else begin
            if (bi1.write_en) rf1[bi1.write_reg] <= bi1.write_value;
            if (bi3.write_en) rf3[bi3.write_reg] <= bi3.write_value;
        end
        p1  <= bi1.read_en ? rf1[bi1.read_reg] : 32'hDEADBEEF;
        p3a <= bi3.read_en ? rf3[bi3.read_reg] : 32'hDEADBEEF;
        p3b <= p3a;
        p3c <= p3b;
    end

    assign bi1.read_value = p1;
    assign bi3.read_value = p3c;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc, lr, r3;
        logic [1:0]  mode;
        logic        cond;
        logic [23:0] off;
        logic [3:0]  rm;
        logic        hold;
        int          lat1, lat3;
        logic [31:0] exp_pc, exp_lr;
        int          nlr, nt;
        logic        tv;
    } vec_t;

    vec_t vt[$];

    int lat[2], npc[2], nlr[2], nt[2], tvs[2], both[2], bbad[2], lrc[2], pcc[2];
    bit dn[2];

    task automatic poke(input logic [3:0] r, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_reg = r; poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic samp(input int k, input int cyc, input logic busy, input logic done,
                        input logic rd, input logic wr, input logic [3:0] wreg,
                        input logic tw, input logic tv);
        if (rd && wr) both[k]++;
        if (wr && wreg == 4'd15) begin npc[k]++; pcc[k] = cyc; end
        if (wr && wreg == 4'd14) begin nlr[k]++; lrc[k] = cyc; end
        if (tw) begin nt[k]++; tvs[k] = int'(tv); end
        if (!dn[k]) begin
            if (done) begin
                dn[k] = 1'b1; lat[k] = cyc;
                if (busy) bbad[k]++;
            end else if (!busy) begin
                bbad[k]++;
            end
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int extra;
        string t;
        for (int k = 0; k < 2; k++) begin
            lat[k] = 0; npc[k] = 0; nlr[k] = 0; nt[k] = 0; tvs[k] = 0;
            both[k] = 0; bbad[k] = 0; lrc[k] = 0; pcc[k] = 0; dn[k] = 1'b0;
        end
        poke(4'd15, v.pc);
        poke(4'd14, v.lr);
        poke(4'd3,  v.r3);
        @(negedge clk);
        en1 = 1'b1; en3 = 1'b1;
        mode = v.mode; cond = v.cond; offset = v.off; rm = v.rm;
        extra = 0;
        for (int cyc = 1; cyc <= 60 && extra < 4; cyc++) begin
            @(negedge clk);
            // operands must have been latched; scramble the live inputs
            mode = ~v.mode; cond = ~v.cond; offset = 24'h5A5A5A; rm = 4'h9;
            if (!v.hold) begin en1 = 1'b0; en3 = 1'b0; end
            samp(0, cyc, bi1.busy, bi1.done, bi1.read_en, bi1.write_en, bi1.write_reg,
                 bi1.t_write_en, bi1.t_value);
            samp(1, cyc, bi3.busy, bi3.done, bi3.read_en, bi3.write_en, bi3.write_reg,
                 bi3.t_write_en, bi3.t_value);
            if (dn[0]) en1 = 1'b0;
            if (dn[1]) en3 = 1'b0;
            if (dn[0] && dn[1]) extra++;
        end
        en1 = 1'b0; en3 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t = $sformatf("v%0d_L%0d", idx, (k == 0) ? 1 : 3);
            chk({t, "_lat"},  lat[k], (k == 0) ? v.lat1 : v.lat3);
            chk({t, "_pc"},   (k == 0) ? rf1[15] : rf3[15], v.exp_pc);
            chk({t, "_lr"},   (k == 0) ? rf1[14] : rf3[14], v.exp_lr);
            chk({t, "_npc"},  npc[k], 1);
            chk({t, "_nlr"},  nlr[k], v.nlr);
            chk({t, "_nt"},   nt[k], v.nt);
            chk({t, "_tval"}, tvs[k], 32'(v.tv));
            chk({t, "_excl"}, both[k], 0);
            chk({t, "_busy"}, bbad[k], 0);
            if (v.nlr > 0) chk({t, "_order"}, 32'(lrc[k] < pcc[k]), 32'd1);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl1"}, 32'({bi1.busy, bi1.done, bi1.read_en, bi1.read_reg, bi1.write_en,
                                 bi1.write_reg, bi1.t_write_en, bi1.t_value}), 32'd0);
        chk({tag, "_wv1"},  bi1.write_value, 32'd0);
        chk({tag, "_ctl3"}, 32'({bi3.busy, bi3.done, bi3.read_en, bi3.read_reg, bi3.write_en,
                                 bi3.write_reg, bi3.t_write_en, bi3.t_value}), 32'd0);
        chk({tag, "_wv3"},  bi3.write_value, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en1 = 1'b0; en3 = 1'b0; cond = 1'b0; mode = 2'd0; offset = 24'd0; rm = 4'd0;
        poke_en = 1'b0; poke_reg = 4'd0; poke_val = 32'd0;

        //           pc            lr            r3            mode  cond  off          rm     hold  L1 L3 exp_pc        exp_lr        nlr nt tv
        vt.push_back('{32'h00001000, 32'hAAAA0000, 32'h00000000, 2'd0, 1'b0, 24'h000000, 4'd0,  1'b0, 4, 6, 32'h00001004, 32'hAAAA0000, 0, 0, 1'b0});
        vt.push_back('{32'h00001004, 32'hAAAA0000, 32'h00000000, 2'd0, 1'b1, 24'h000003, 4'd0,  1'b0, 4, 6, 32'h00001018, 32'hAAAA0000, 0, 0, 1'b0});
        vt.push_back('{32'h00002000, 32'hAAAA0000, 32'h00000000, 2'd1, 1'b1, 24'hFFFFFE, 4'd0,  1'b0, 5, 7, 32'h00002000, 32'h00002004, 1, 0, 1'b0});
        vt.push_back('{32'h00002000, 32'hAAAA0000, 32'h00008001, 2'd2, 1'b1, 24'h000000, 4'd3,  1'b0, 7, 11, 32'h00008000, 32'hAAAA0000, 0, 1, 1'b1});
        vt.push_back('{32'h00002000, 32'hAAAA0000, 32'h00008000, 2'd2, 1'b1, 24'h000000, 4'd3,  1'b0, 7, 11, 32'h00008000, 32'hAAAA0000, 0, 1, 1'b0});
        vt.push_back('{32'h00004000, 32'h00003000, 32'h00000000, 2'd3, 1'b1, 24'h000000, 4'd14, 1'b0, 8, 12, 32'h00003000, 32'h00004004, 1, 1, 1'b0});
        vt.push_back('{32'h00004000, 32'h00004004, 32'h00000000, 2'd2, 1'b1, 24'h000000, 4'd15, 1'b0, 4, 6, 32'h00004008, 32'h00004004, 0, 1, 1'b0});
        vt.push_back('{32'hFFFFFFFC, 32'hAAAA0000, 32'h00000000, 2'd0, 1'b1, 24'h000000, 4'd0,  1'b0, 4, 6, 32'h00000004, 32'hAAAA0000, 0, 0, 1'b0});
        vt.push_back('{32'h00000100, 32'hAAAA0000, 32'h00000000, 2'd0, 1'b1, 24'h000001, 4'd0,  1'b1, 4, 6, 32'h0000010C, 32'hAAAA0000, 0, 0, 1'b0});
        vt.push_back('{32'h00000500, 32'hAAAA0000, 32'h00000000, 2'd3, 1'b1, 24'h000000, 4'd15, 1'b0, 5, 7, 32'h00000508, 32'h00000504, 1, 1, 1'b0});
        vt.push_back('{32'h00000600, 32'hAAAA0000, 32'h00008001, 2'd3, 1'b0, 24'h000000, 4'd3,  1'b0, 4, 6, 32'h00000604, 32'hAAAA0000, 0, 0, 1'b0});
        vt.push_back('{32'h02000000, 32'hAAAA0000, 32'h00000000, 2'd0, 1'b1, 24'h800000, 4'd0,  1'b0, 4, 6, 32'h00000008, 32'hAAAA0000, 0, 0, 1'b0});

        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;

        foreach (vt[i]) run(i, vt[i]);

        // abort in WAIT_PC: outputs clear at once and PC stays put
        poke(4'd15, 32'h00000700);
        @(negedge clk);
        en1 = 1'b1; en3 = 1'b1; mode = 2'd0; cond = 1'b1; offset = 24'h000004; rm = 4'd0;
        @(negedge clk);
        en1 = 1'b0; en3 = 1'b0;
        @(negedge clk);
        chk("abort_busy1", 32'(bi1.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_pc1", rf1[15], 32'h00000700);
        chk("abort_pc3", rf3[15], 32'h00000700);
        chk("abort_idle1", 32'(bi1.busy), 32'd0);
        chk("abort_idle3", 32'(bi3.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Parametrised successor to the single-mode branch block in the arm7 core.
- Executes B, BL, BX and BLX(register) against the register file through one read port and one write port.
- Adds a start/busy/done handshake, configurable register-file read latency, Thumb-bit output and a Rm operand path.
- Sits between the decoder (issues en + operands) and register_file (PC/LR/Rm access).

Parameters:
DATA_W, 32, register/PC width
OFFSET_W, 24, branch immediate width (two's complement)
OFFSET_SHIFT, 2, left shift applied to the sign-extended offset
PC_AHEAD, 8, pipeline PC bias added to PC for the target and for Rm==15 reads
INSTR_BYTES, 4, increment for the not-taken PC and for the LR value
RF_RD_LAT, 1, cycles from the read_en edge to a valid read_value (1..4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  start request; accepted only in IDLE
cond  in  1  condition result; 0 = not taken
mode  in  2  00 B, 01 BL, 10 BX, 11 BLX(reg)
offset  in  OFFSET_W  immediate for B/BL
rm  in  4  source register for BX/BLX
busy  out  1  high from the acceptance edge until done is asserted
done  out  1  one-cycle completion pulse
write_en  out  1  register file write strobe
write_reg  out  4  register file write index
write_value  out  DATA_W  register file write data
read_en  out  1  register file read strobe
read_reg  out  4  register file read index
read_value  in  DATA_W  register file read data
t_write_en  out  1  one-cycle strobe updating the CPSR T bit
t_value  out  1  new T bit value

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including busy, done, write_*, read_*, t_*. The latched operands are cleared.
- All outputs are registered.
- On a rising edge in IDLE with en=1, latch cond, mode, offset and rm, set busy=1, and leave IDLE. en is ignored while busy=1.
- States: IDLE -> RD_PC -> WAIT_PC -> [RD_RM -> WAIT_RM] -> [WR_LR] -> WR_PC -> DONE -> IDLE.
- RD_PC: read_en=1 and read_reg=15 for exactly one cycle.
- WAIT_PC: wait RF_RD_LAT cycles, then capture read_value as pc.
- RD_RM / WAIT_RM: entered only when cond=1 and mode[1]=1. Same handshake as the PC read, with read_reg=rm, captured as rmv.
  - If rm==15, the read is skipped and rmv = pc + PC_AHEAD.
- WR_LR: entered only when cond=1 and mode[0]=1. write_en=1, write_reg=14, write_value = pc + INSTR_BYTES, for one cycle.
- WR_PC: write_en=1 and write_reg=15 for one cycle. write_value depends on the case:
  - cond=0: pc + INSTR_BYTES. No LR write, no T write.
  - B/BL: pc + PC_AHEAD + (sign_extend(offset) << OFFSET_SHIFT).
  - BX/BLX: rmv with bit 0 cleared. In the same cycle, t_write_en=1 and t_value=rmv[0].
- DONE: done=1 for one cycle, busy=0 in the same cycle, then return to IDLE. A new en can be accepted on the next edge.
- Arithmetic is modulo 2^DATA_W; wrap-around is silent.
- The sign extension goes from OFFSET_W to DATA_W before shifting.
- BLX with rm==14: Rm is read before LR is written, so the old LR is the target.
- At most one of read_en and write_en is high in any cycle.
- Latency from acceptance edge to done cycle, with RF_RD_LAT=L:
  - B or not taken: 3+L.
  - BL: 4+L.
  - BX: 5+2L.
  - BLX: 6+2L.
  - With rm==15, the BX/BLX values shrink by 2+L.
- Reset mid-operation aborts immediately and no further writes are issued. A completed LR write is not rolled back.

Test Plan:
- PC=0x1000, en with cond=0 and mode=B -> PC=0x1004, LR unchanged, done after 4 cycles (L=1), t_write_en never high.
- PC=0x1004, B with cond=1 and offset=3 -> PC=0x1018, one PC write only.
- PC=0x2000, BL with offset=0xFFFFFE -> LR=0x2004, PC=0x2000, LR write precedes PC write, done at cycle 5.
- R3=0x00008001, BX r3 -> PC=0x8000, t_write_en pulse with t_value=1. Repeat with R3=0x8000 -> t_value=0.
- LR=0x3000, PC=0x4000, BLX r14 -> PC=0x3000, LR=0x4004. Then PC=0x4000, BX r15 -> PC=0x4008, t_value=0.
- Corner cases:
  - PC=0xFFFFFFFC, B with offset=0 -> PC=0x00000004 (wrap).
  - en held high while busy -> exactly one execution.
  - RF_RD_LAT=3 instance -> same results.
  - rst_n pulsed low in WAIT_PC -> all outputs 0, PC unchanged.
